// File: rtl/led_mode_if.sv
// led_mode_if: button, auto-cycle, LED vector and mode status bundle for led_mode_select
interface led_mode_if;
  logic        btn_next;
  logic        auto_en;
  logic [31:0] led_in;
  logic [7:0]  led_out;
  logic [1:0]  mode;
  logic        blanking;
  modport master(output btn_next, auto_en, led_in, input led_out, mode, blanking);
  modport slave(input btn_next, auto_en, led_in, output led_out, mode, blanking);
endinterface

// File: rtl/led_mode_select.sv
// led_mode_select: picks one LED mode vector, advancing on debounced press or auto timer with a blank window
module led_mode_select #(
  parameter int          NUM_MODES    = 4,
  parameter logic [19:0] DEBOUNCE_CYC = 20'd480000,
  parameter logic [15:0] BLANK_CYC    = 16'd2400,
  parameter logic [25:0] AUTO_CYC     = 26'd24000000
) (
  input logic       clk,
  input logic       rst,
  led_mode_if.slave lif
);
  typedef enum logic {RUN, BLANK} state_t;
  localparam logic [1:0] LAST = 2'(NUM_MODES - 1);
  state_t      state_q, state_d;
  logic        s1_q, s2_q;
  logic        level_q, level_d, press_q, press_d, deb_hit;
  logic [19:0] deb_cnt_q, deb_cnt_d;
  logic [15:0] blank_cnt_q, blank_cnt_d;
  logic [25:0] auto_cnt_q, auto_cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  led_q, led_d;
  logic        blanking_q, blanking_d;
  logic        auto_tick, advance;
  always_comb begin
    deb_hit     = (s2_q != level_q) && (deb_cnt_q == DEBOUNCE_CYC - 20'd1);
    deb_cnt_d   = (s2_q == level_q || deb_hit) ? '0 : deb_cnt_q + 20'd1;
    level_d     = deb_hit ? s2_q : level_q;
    press_d     = deb_hit & s2_q;
    auto_tick   = lif.auto_en && state_q == RUN && auto_cnt_q == AUTO_CYC - 26'd1;
    advance     = press_q | auto_tick;
    auto_cnt_d  = (!lif.auto_en || state_q != RUN || advance) ? '0 : auto_cnt_q + 26'd1;
    state_d     = state_q;
    mode_d      = mode_q;
    blank_cnt_d = blank_cnt_q;
    blanking_d  = blanking_q;
    led_d       = 8'hFF;
    if (state_q == RUN) begin
      // the switch edge itself already shows dark LEDs so blanking and FF line up
      led_d = advance ? 8'hFF : lif.led_in[{mode_q, 3'b000} +: 8];
      if (advance) begin
        mode_d      = (mode_q >= LAST) ? 2'd0 : mode_q + 2'd1;
        blank_cnt_d = '0;
        blanking_d  = 1'b1;
        state_d     = BLANK;
      end
    end else begin
      blank_cnt_d = blank_cnt_q + 16'd1;
      if (blank_cnt_q == BLANK_CYC - 16'd1) begin
        blanking_d = 1'b0;
        state_d    = RUN;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      deb_cnt_q   <= '0;
      blank_cnt_q <= '0;
      auto_cnt_q  <= '0;
      mode_q      <= 2'd0;
      led_q       <= 8'hFF;
      blanking_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= lif.btn_next;
      s2_q        <= s1_q;
      level_q     <= level_d;
      press_q     <= press_d;
      deb_cnt_q   <= deb_cnt_d;
      blank_cnt_q <= blank_cnt_d;
      auto_cnt_q  <= auto_cnt_d;
      mode_q      <= mode_d;
      led_q       <= led_d;
      blanking_q  <= blanking_d;
    end
  end
  assign lif.led_out  = led_q;
  assign lif.mode     = mode_q;
  assign lif.blanking = blanking_q;
endmodule

// File: tb/tb_led_mode_select.sv
// tb_led_mode_select: scoreboard bench; stimulus queues expected switches, a monitor checks each one
module tb_led_mode_select;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en3 = 1'b0;
  logic rst3;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  typedef struct {
    logic [1:0] mode;
    int         cyc;
    logic [7:0] led;
  } exp_t;
  exp_t sb[$];
  led_mode_if lif();
  led_mode_if if3();
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rst3         = rst | ~en3;
  assign if3.btn_next = lif.btn_next;
  assign if3.auto_en  = 1'b0;
  assign if3.led_in   = lif.led_in;
  led_mode_select #(.NUM_MODES(4), .DEBOUNCE_CYC(20'd8), .BLANK_CYC(16'd4), .AUTO_CYC(26'd32))
    dut (.clk(clk), .rst(rst), .lif(lif));
  led_mode_select #(.NUM_MODES(3), .DEBOUNCE_CYC(20'd8), .BLANK_CYC(16'd4), .AUTO_CYC(26'd32))
    dut3 (.clk(clk), .rst(rst3), .lif(if3));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask
  task automatic press(input logic [1:0] m, input logic [7:0] l);
    sb.push_back('{m, cyc + 11, l});
    lif.btn_next = 1'b1;
    step(20);
    lif.btn_next = 1'b0;
    step(15);
  endtask
  logic [1:0] prev_mode = 2'd0;
  logic [7:0] want_led = 8'h00;
  bit         in_blank = 1'b0;
  bit         chk_led = 1'b0;
  int         blank_len = 0;
  exp_t       e;
  always @(negedge clk) begin
    if (rst) begin
      prev_mode = 2'd0;
      in_blank  = 1'b0;
      chk_led   = 1'b0;
    end else begin
      if (in_blank) begin
        if (lif.blanking) begin
          blank_len++;
          check("blank_led", lif.led_out, 8'hFF);
        end else begin
          check("blank_len", blank_len, 4);
          check("led_blank_exit", lif.led_out, 8'hFF);
          chk_led  = 1'b1;
          in_blank = 1'b0;
        end
      end else if (chk_led) begin
        check("led_after_blank", lif.led_out, want_led);
        chk_led = 1'b0;
      end
      if (lif.mode !== prev_mode) begin
        check("switch_expected", sb.size(), (sb.size() == 0) ? 1 : sb.size());
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("switch_mode", lif.mode, e.mode);
          check("switch_cycle", cyc, e.cyc);
          check("switch_blanking", lif.blanking, 1'b1);
          check("switch_led", lif.led_out, 8'hFF);
          want_led  = e.led;
          in_blank  = 1'b1;
          blank_len = 1;
        end
      end
      prev_mode = lif.mode;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int k;
    logic [1:0] m4 [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] l4 [4] = '{8'h22, 8'h33, 8'h44, 8'h11};
    logic [1:0] m3 [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
    logic [7:0] l3 [4] = '{8'h22, 8'h33, 8'h11, 8'h22};
    lif.btn_next = 1'b0;
    lif.auto_en  = 1'b0;
    lif.led_in   = 32'h44332211;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("rst_led", lif.led_out, 8'hFF);
      check("rst_mode", lif.mode, 2'd0);
      check("rst_blanking", lif.blanking, 1'b0);
    end
    rst = 1'b0;
    check("release_led", lif.led_out, 8'hFF);
    step(1);
    check("run_led_mode0", lif.led_out, 8'h11);
    check("run_mode0", lif.mode, 2'd0);
    press(2'd1, 8'h22);
    for (int i = 0; i < 10; i++) begin
      lif.btn_next = (i % 2 == 0);
      step(3);
    end
    press(2'd2, 8'h33);
    press(2'd3, 8'h44);
    press(2'd0, 8'h11);
    en3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      press(m4[i], l4[i]);
      check("wrap3_mode", if3.mode, m3[i]);
      check("wrap3_led", if3.led_out, l3[i]);
    end
    k = cyc;
    lif.auto_en = 1'b1;
    sb.push_back('{2'd1, k + 32, 8'h22});
    sb.push_back('{2'd2, k + 68, 8'h33});
    sb.push_back('{2'd3, k + 104, 8'h44});
    sb.push_back('{2'd0, k + 140, 8'h11});
    sb.push_back('{2'd1, k + 176, 8'h22});
    wait_until(k + 93);
    lif.btn_next = 1'b1;
    wait_until(k + 113);
    lif.btn_next = 1'b0;
    wait_until(k + 131);
    lif.btn_next = 1'b1;
    wait_until(k + 151);
    lif.btn_next = 1'b0;
    wait_until(k + 185);
    lif.auto_en = 1'b0;
    check("auto_final_mode", lif.mode, 2'd1);
    step(20);
    k = cyc;
    sb.push_back('{2'd2, k + 11, 8'h33});
    lif.btn_next = 1'b1;
    wait_until(k + 12);
    lif.btn_next = 1'b0;
    wait_until(k + 13);
    check("pre_rst_blanking", lif.blanking, 1'b1);
    rst = 1'b1;
    step(1);
    check("midblank_rst_mode", lif.mode, 2'd0);
    check("midblank_rst_blanking", lif.blanking, 1'b0);
    check("midblank_rst_led", lif.led_out, 8'hFF);
    rst = 1'b0;
    step(1);
    check("post_rst_led", lif.led_out, 8'h11);
    step(5);
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
